// File: rtl/canvas_buffer_arbiter_if.sv
// canvas_buffer_arbiter_if: VGA read, paint, clear and RAM signals of the canvas buffer arbiter.
interface canvas_buffer_arbiter_if #(
    parameter int ADDR_W  = 12,
    parameter int COLOR_W = 3
) ();
    logic               vga_rd_en;
    logic [ADDR_W-1:0]  vga_rd_addr;
    logic [COLOR_W-1:0] vga_rd_data;
    logic               vga_rd_valid;
    logic               paint_req;
    logic [5:0]         paint_x;
    logic [5:0]         paint_y;
    logic [COLOR_W-1:0] paint_color;
    logic               paint_ack;
    logic               clear_start;
    logic [COLOR_W-1:0] clear_color;
    logic               clear_busy;
    logic               clear_done;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem_rdata;
    // master: requesters plus the RAM; slave: the arbiter itself
    modport master (
        output vga_rd_en, vga_rd_addr, paint_req, paint_x, paint_y, paint_color,
               clear_start, clear_color, mem_rdata,
        input  vga_rd_data, vga_rd_valid, paint_ack, clear_busy, clear_done,
               mem_addr, mem_we, mem_wdata
    );
    modport slave (
        input  vga_rd_en, vga_rd_addr, paint_req, paint_x, paint_y, paint_color,
               clear_start, clear_color, mem_rdata,
        output vga_rd_data, vga_rd_valid, paint_ack, clear_busy, clear_done,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/canvas_buffer_arbiter.sv
// canvas_buffer_arbiter: shares the single-port canvas RAM between VGA reads, a clear sweep and paint writes.
// Priority per cycle is VGA read > clear write > paint write; RAM signals are driven in the grant cycle.
module canvas_buffer_arbiter #(
    parameter int COLS    = 48,
    parameter int ROWS    = 48,
    parameter int ADDR_W  = 12,
    parameter int COLOR_W = 3
) (
    input logic                    dclk,
    input logic                    clr,
    canvas_buffer_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS * COLS - 1);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d, addr_q, addr_d, paint_addr;
    logic [COLOR_W-1:0] fill_q, fill_d, rd_data_q, rd_data_d, wdata;
    logic               rd_valid_q, rd_valid_d, hold_q, hold_d;
    logic               vga_gnt, clr_gnt, paint_gnt, paint_ok, paint_wr;

    // grants are forced off while clr is high so every output reads 0 during reset
    always_comb begin
        vga_gnt    = !clr && bus.vga_rd_en;
        clr_gnt    = !clr && !bus.vga_rd_en && state_q == SWEEP;
        paint_gnt  = !clr && !bus.vga_rd_en && state_q == IDLE && !bus.clear_start && bus.paint_req && !hold_q;
        paint_ok   = 32'(bus.paint_x) < COLS && 32'(bus.paint_y) < ROWS;
        paint_wr   = paint_gnt && paint_ok;
        paint_addr = ADDR_W'(bus.paint_y) * ADDR_W'(COLS) + ADDR_W'(bus.paint_x);
        addr_d     = vga_gnt ? bus.vga_rd_addr : clr_gnt ? cnt_q : paint_wr ? paint_addr : addr_q;
        wdata      = clr_gnt ? fill_q : paint_wr ? bus.paint_color : '0;
        rd_valid_d = vga_gnt;
        rd_data_d  = rd_valid_q ? bus.mem_rdata : rd_data_q;
        hold_d     = bus.paint_req && (hold_q || paint_gnt);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: if (bus.clear_start) begin
                state_d = SWEEP;
                cnt_d   = '0;
                fill_d  = bus.clear_color;
            end
            SWEEP: if (clr_gnt) begin
                state_d = cnt_q == LAST ? DONE : SWEEP;
                cnt_d   = cnt_q == LAST ? '0 : cnt_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.clear_busy   = state_q == SWEEP;
        bus.clear_done   = state_q == DONE;
        bus.mem_addr     = addr_d;
        bus.mem_we       = clr_gnt || paint_wr;
        bus.mem_wdata    = wdata;
        bus.paint_ack    = paint_gnt;
        bus.vga_rd_valid = rd_valid_q;
        bus.vga_rd_data  = rd_data_d;
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            hold_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            hold_q     <= hold_d;
        end
    end
endmodule

// File: tb/tb_canvas_buffer_arbiter.sv
// tb_canvas_buffer_arbiter: directed and randomized checks of the canvas arbiter against a
// cell-array reference model, with a 1-cycle-latency RAM model attached to the memory port.
module tb_canvas_buffer_arbiter;
    localparam int COLS = 48, ROWS = 48, CELLS = 2304;
    logic dclk = 1'b0;
    logic clr  = 1'b1;
    int checks = 0, failures = 0;
    logic [2:0] ram [CELLS];
    logic [2:0] ref_mem [CELLS];

    canvas_buffer_arbiter_if #(.ADDR_W(12), .COLOR_W(3)) bus ();
    canvas_buffer_arbiter #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .COLOR_W(3)) dut (
        .dclk(dclk), .clr(clr), .bus(bus.slave));

    always #5 dclk = ~dclk;

    always @(posedge dclk) begin
        if (bus.mem_we && bus.mem_addr < 12'(CELLS)) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bus.mem_addr < 12'(CELLS) ? ram[bus.mem_addr] : 3'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic idle_in();
        bus.vga_rd_en = 0; bus.vga_rd_addr = 0; bus.paint_req = 0; bus.paint_x = 0; bus.paint_y = 0;
        bus.paint_color = 0; bus.clear_start = 0; bus.clear_color = 0;
    endtask

    task automatic paint(input int x, input int y, input int c, input string tag);
        bit ok;
        ok = x < COLS && y < ROWS;
        bus.paint_req = 1; bus.paint_x = 6'(x); bus.paint_y = 6'(y); bus.paint_color = 3'(c);
        @(negedge dclk);
        chk({tag, "_ack"}, bus.paint_ack, 1);
        chk({tag, "_we"}, bus.mem_we, 32'(ok));
        if (ok) begin
            chk({tag, "_addr"}, bus.mem_addr, y * COLS + x);
            chk({tag, "_wdata"}, bus.mem_wdata, c);
            ref_mem[y * COLS + x] = 3'(c);
        end
        tick();
        bus.paint_req = 0;
        tick();
    endtask

    task automatic rd(input int a, input string tag);
        bus.vga_rd_en = 1; bus.vga_rd_addr = 12'(a);
        @(negedge dclk);
        chk({tag, "_raddr"}, bus.mem_addr, a);
        chk({tag, "_rwe"}, bus.mem_we, 0);
        tick();
        bus.vga_rd_en = 0;
        @(negedge dclk);
        chk({tag, "_valid"}, bus.vga_rd_valid, 1);
        chk({tag, "_data"}, bus.vga_rd_data, ref_mem[a]);
        tick();
    endtask

    // one full clear; vga=1 steals the first cycle of every group of four sweep cycles
    task automatic sweep(input int c, input bit vga, output int writes, output int order_err,
                         output int vga_wr, output int busy_cyc, output int done_at, output int acks);
        writes = 0; order_err = 0; vga_wr = 0; busy_cyc = 0; done_at = -1; acks = 0;
        bus.clear_start = 1; bus.clear_color = 3'(c);
        @(negedge dclk);
        chk("start_cycle_ack", bus.paint_ack, 0);
        chk("start_cycle_we", bus.mem_we, 0);
        tick();
        bus.clear_start = 0; bus.clear_color = 3'($urandom_range(0, 7));
        for (int k = 1; k < 6000 && done_at < 0; k++) begin
            bus.vga_rd_en = vga && ((k - 1) % 4 == 0);
            bus.vga_rd_addr = 12'($urandom_range(0, CELLS - 1));
            if (k == 5) bus.clear_start = 1;
            if (k == 6) bus.clear_start = 0;
            @(negedge dclk);
            if (bus.clear_done) done_at = k;
            if (bus.clear_busy) busy_cyc++;
            if (bus.paint_ack) acks++;
            if (bus.mem_we) begin
                if (bus.mem_addr != 12'(writes) || bus.mem_wdata != 3'(c)) order_err++;
                if (bus.vga_rd_en) vga_wr++;
                writes++;
            end
            tick();
        end
        bus.vga_rd_en = 0;
        for (int i = 0; i < CELLS; i++) ref_mem[i] = 3'(c);
    endtask

    initial begin
        int w, oe, vw, bc, da, ac, found, done_seen;
        for (int i = 0; i < CELLS; i++) begin ram[i] = 0; ref_mem[i] = 0; end
        idle_in();
        bus.vga_rd_en = 1; bus.vga_rd_addr = 12'd77;
        tick(); tick();
        @(negedge dclk);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_done", bus.clear_done, 0);
        chk("rst_ack", bus.paint_ack, 0);
        chk("rst_valid", bus.vga_rd_valid, 0);
        chk("rst_rdata", bus.vga_rd_data, 0);
        tick();
        idle_in();
        clr = 0;
        tick();

        // paint held across its ack is served exactly once
        bus.paint_req = 1; bus.paint_x = 5; bus.paint_y = 2; bus.paint_color = 3;
        @(negedge dclk);
        chk("t1_ack", bus.paint_ack, 1);
        chk("t1_we", bus.mem_we, 1);
        chk("t1_addr", bus.mem_addr, 101);
        chk("t1_wdata", bus.mem_wdata, 3);
        ref_mem[101] = 3;
        tick();
        @(negedge dclk);
        chk("t1_held_ack", bus.paint_ack, 0);
        chk("t1_held_we", bus.mem_we, 0);
        chk("t1_held_addr", bus.mem_addr, 101);
        tick();
        bus.paint_req = 0;
        tick();

        // VGA reads block a pending paint
        bus.vga_rd_en = 1; bus.vga_rd_addr = 101;
        bus.paint_req = 1; bus.paint_x = 10; bus.paint_y = 10; bus.paint_color = 5;
        for (int k = 0; k < 3; k++) begin
            @(negedge dclk);
            chk("t2_ack_blocked", bus.paint_ack, 0);
            chk("t2_we", bus.mem_we, 0);
            chk("t2_addr", bus.mem_addr, 101);
            if (k > 0) begin
                chk("t2_valid", bus.vga_rd_valid, 1);
                chk("t2_data", bus.vga_rd_data, 3);
            end
            tick();
        end
        bus.vga_rd_en = 0;
        @(negedge dclk);
        chk("t2_ack", bus.paint_ack, 1);
        chk("t2_paint_addr", bus.mem_addr, 490);
        chk("t2_last_valid", bus.vga_rd_valid, 1);
        chk("t2_last_data", bus.vga_rd_data, 3);
        ref_mem[490] = 5;
        tick();
        bus.paint_req = 0;
        tick();
        @(negedge dclk);
        chk("t2_valid_drop", bus.vga_rd_valid, 0);
        chk("t2_data_hold", bus.vga_rd_data, 3);
        tick();

        for (int n = 0; n < 16; n++) begin
            paint($urandom_range(0, 55), $urandom_range(0, 55), $urandom_range(0, 7), "rnd_paint");
            rd($urandom_range(0, CELLS - 1), "rnd_read");
            rd(490, "rnd_read490");
        end
        paint(48, 0, 6, "oob_x");
        paint(0, 48, 6, "oob_y");
        paint(47, 47, 6, "corner");
        rd(CELLS - 1, "corner_read");

        sweep(7, 1'b0, w, oe, vw, bc, da, ac);
        chk("t3_writes", w, 2304);
        chk("t3_order", oe, 0);
        chk("t3_busy_cycles", bc, 2304);
        chk("t3_done_at", da, 2305);
        @(negedge dclk);
        chk("t3_done_pulse", bus.clear_done, 0);
        chk("t3_busy_after", bus.clear_busy, 0);
        tick();
        rd($urandom_range(0, CELLS - 1), "t3_read");
        rd(CELLS - 1, "t3_read_last");

        sweep(2, 1'b1, w, oe, vw, bc, da, ac);
        chk("t4_writes", w, 2304);
        chk("t4_order", oe, 0);
        chk("t4_vga_cycle_writes", vw, 0);
        chk("t4_busy_cycles", bc, 3072);
        chk("t4_done_at", da, 3073);
        tick();

        // clear and paint in the same cycle: clear first, paint right after
        bus.paint_req = 1; bus.paint_x = 0; bus.paint_y = 0; bus.paint_color = 1;
        sweep(4, 1'b0, w, oe, vw, bc, da, ac);
        chk("t5_writes", w, 2304);
        chk("t5_acks_during_sweep", ac, 0);
        @(negedge dclk);
        chk("t5_ack", bus.paint_ack, 1);
        chk("t5_we", bus.mem_we, 1);
        chk("t5_addr", bus.mem_addr, 0);
        chk("t5_wdata", bus.mem_wdata, 1);
        ref_mem[0] = 1;
        tick();
        bus.paint_req = 0;
        tick();
        rd(0, "t5_read0");
        rd(1, "t5_read1");

        // reset in the middle of a sweep
        bus.clear_start = 1; bus.clear_color = 5;
        tick();
        bus.clear_start = 0;
        found = 0;
        for (int k = 0; k < 3000 && found == 0; k++) begin
            @(negedge dclk);
            if (bus.mem_we && bus.mem_addr == 12'd1000) found = 1;
            else tick();
        end
        chk("t6_reached_1000", found, 1);
        for (int i = 0; i < 1000; i++) ref_mem[i] = 5;
        #1 clr = 1;
        #1;
        chk("t6_busy_now", bus.clear_busy, 0);
        chk("t6_we_now", bus.mem_we, 0);
        chk("t6_done_now", bus.clear_done, 0);
        tick();
        clr = 0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge dclk);
            if (bus.clear_done || bus.clear_busy) done_seen++;
            tick();
        end
        chk("t6_no_done", done_seen, 0);
        rd(999, "t6_read999");
        rd(1000, "t6_read1000");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
